// File: rtl/perf_event_counters.sv
// Performance event-counter bank: per-channel event counts plus a cycle counter,
// frozen on halt and streamed out through a valid/ready dump port.
module perf_event_counters #(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned IDX_W   = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              halt,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              cyc_ovf,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [CNT_W-1:0]  dump_data,
  output logic              done
);

  typedef enum logic [1:0] {StRun, StDump, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_d [NUM_CH];
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic                cyc_ovf_q, cyc_ovf_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ovf_d     = ovf_q;
    cyc_ovf_d = cyc_ovf_q;
    ptr_d     = ptr_q;
    for (int i = 0; i < NUM_CH; i++) cnt_d[i] = cnt_q[i];

    unique case (state_q)
      StRun: begin
        if (clear) begin
          // Clear beats same-cycle events; a coincident halt dumps the zeros.
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
          cyc_d     = '0;
          ovf_d     = '0;
          cyc_ovf_d = 1'b0;
        end else begin
          if (&cyc_q) begin
            cyc_d     = SATURATE ? cyc_q : '0;
            cyc_ovf_d = 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
          for (int i = 0; i < NUM_CH; i++) begin
            if (en && event_in[i]) begin
              if (&cnt_q[i]) begin
                cnt_d[i] = SATURATE ? cnt_q[i] : '0;
                ovf_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
        end
        if (halt) begin
          state_d = StDump;
          ptr_d   = '0;
        end
      end
      StDump: begin
        if (dump_ready) begin
          if (ptr_q == LastIdx) state_d = StDone;
          else                  ptr_d   = ptr_q + 1'b1;
        end
      end
      StDone: begin
        if (clear) begin
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
          cyc_d     = '0;
          ovf_d     = '0;
          cyc_ovf_d = 1'b0;
          ptr_d     = '0;
          state_d   = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cyc_q     <= '0;
      ovf_q     <= '0;
      cyc_ovf_q <= 1'b0;
      ptr_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
      cyc_ovf_q <= cyc_ovf_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel == LastIdx) rd_data = cyc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == IDX_W'(i)) rd_data = cnt_q[i];
    end
  end

  always_comb begin
    dump_data = '0;
    if (state_q == StDump) begin
      if (ptr_q == LastIdx) dump_data = cyc_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ptr_q == IDX_W'(i)) dump_data = cnt_q[i];
      end
    end
  end

  assign dump_valid = (state_q == StDump);
  assign done       = (state_q == StDone);
  assign dump_idx   = ptr_q;
  assign ovf        = ovf_q;
  assign cyc_ovf    = cyc_ovf_q;

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a 5-channel/32-bit bank for dump flow
// and two 2-channel/4-bit banks (saturate and wrap) for overflow and clear.
module tb_perf_event_counters;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 5-channel, 32-bit bank
  logic        en, halt, clear, dump_ready;
  logic [4:0]  ev;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data, dump_data;
  logic [4:0]  ovf;
  logic        cyc_ovf, dump_valid, done;
  logic [2:0]  dump_idx;

  // 2-channel, 4-bit banks share inputs
  logic        s_en, s_clear, s_halt, s_ready;
  logic [1:0]  s_ev, s_rd_sel;
  logic [3:0]  sa_rd_data, wr_rd_data, sa_dump_data, wr_dump_data;
  logic [1:0]  sa_ovf, wr_ovf, sa_dump_idx, wr_dump_idx;
  logic        sa_cyc_ovf, wr_cyc_ovf, sa_dump_valid, wr_dump_valid, sa_done, wr_done;

  perf_event_counters #(.NUM_CH(5), .CNT_W(32), .SATURATE(1'b1)) u_big (
    .clk(clk), .rst(rst), .en(en), .event_in(ev), .halt(halt), .clear(clear),
    .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .cyc_ovf(cyc_ovf),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .done(done)
  );

  perf_event_counters #(.NUM_CH(2), .CNT_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(s_en), .event_in(s_ev), .halt(s_halt), .clear(s_clear),
    .rd_sel(s_rd_sel), .rd_data(sa_rd_data), .ovf(sa_ovf), .cyc_ovf(sa_cyc_ovf),
    .dump_valid(sa_dump_valid), .dump_ready(s_ready), .dump_idx(sa_dump_idx),
    .dump_data(sa_dump_data), .done(sa_done)
  );

  perf_event_counters #(.NUM_CH(2), .CNT_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(s_en), .event_in(s_ev), .halt(s_halt), .clear(s_clear),
    .rd_sel(s_rd_sel), .rd_data(wr_rd_data), .ovf(wr_ovf), .cyc_ovf(wr_cyc_ovf),
    .dump_valid(wr_dump_valid), .dump_ready(s_ready), .dump_idx(wr_dump_idx),
    .dump_data(wr_dump_data), .done(wr_done)
  );

  typedef struct {
    int unsigned cycles;
    logic [1:0]  ev;
    logic        en;
    logic        clr;
    logic [3:0]  ch0_sat;
    logic [3:0]  ch0_wrap;
    logic [3:0]  ch1;
    logic [3:0]  cyc_sat;
    logic [3:0]  cyc_wrap;
    logic [1:0]  ovf;
    logic        cyc_ovf;
  } vec_t;

  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_small(input logic [1:0] sel);
    s_rd_sel = sel;
    #1;
  endtask

  task automatic read_big(input logic [2:0] sel);
    rd_sel = sel;
    #1;
  endtask

  logic [31:0] exp_a [6];
  logic [31:0] exp_b [6];
  logic        pat   [4];
  int          ptr;

  initial begin
    vecs[0] = '{32'd17, 2'b01, 1'b1, 1'b0, 4'd15, 4'd1, 4'd0, 4'd15, 4'd1, 2'b01, 1'b1};
    vecs[1] = '{32'd1,  2'b11, 1'b1, 1'b1, 4'd0,  4'd0, 4'd0, 4'd0,  4'd0, 2'b00, 1'b0};
    vecs[2] = '{32'd5,  2'b11, 1'b1, 1'b0, 4'd5,  4'd5, 4'd5, 4'd5,  4'd5, 2'b00, 1'b0};
    vecs[3] = '{32'd1,  2'b11, 1'b1, 1'b1, 4'd0,  4'd0, 4'd0, 4'd0,  4'd0, 2'b00, 1'b0};
    vecs[4] = '{32'd3,  2'b11, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0, 4'd3,  4'd3, 2'b00, 1'b0};
    vecs[5] = '{32'd2,  2'b10, 1'b1, 1'b0, 4'd0,  4'd0, 4'd2, 4'd5,  4'd5, 2'b00, 1'b0};
    exp_a = '{32'd11, 32'd11, 32'd0, 32'd0, 32'd0, 32'd11};
    exp_b = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd3};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; halt = 1'b0; clear = 1'b0; dump_ready = 1'b0; ev = '0; rd_sel = '0;
    s_en = 1'b0; s_clear = 1'b0; s_halt = 1'b0; s_ready = 1'b0; s_ev = '0; s_rd_sel = '0;
    step(); step();

    // Reset state
    check("reset dump_valid", 32'(dump_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    read_big(3'd5);
    check("reset cycle", rd_data, 32'd0);

    // Small banks: table-driven overflow / clear / enable
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      s_ev = vecs[v].ev; s_en = vecs[v].en; s_clear = vecs[v].clr;
      repeat (vecs[v].cycles) step();
      s_ev = '0; s_en = 1'b0; s_clear = 1'b0;
      read_small(2'd0);
      check($sformatf("v%0d sat ch0", v), 32'(sa_rd_data), 32'(vecs[v].ch0_sat));
      check($sformatf("v%0d wrap ch0", v), 32'(wr_rd_data), 32'(vecs[v].ch0_wrap));
      read_small(2'd1);
      check($sformatf("v%0d sat ch1", v), 32'(sa_rd_data), 32'(vecs[v].ch1));
      check($sformatf("v%0d wrap ch1", v), 32'(wr_rd_data), 32'(vecs[v].ch1));
      read_small(2'd2);
      check($sformatf("v%0d sat cyc", v), 32'(sa_rd_data), 32'(vecs[v].cyc_sat));
      check($sformatf("v%0d wrap cyc", v), 32'(wr_rd_data), 32'(vecs[v].cyc_wrap));
      check($sformatf("v%0d sat ovf", v), 32'(sa_ovf), 32'(vecs[v].ovf));
      check($sformatf("v%0d wrap ovf", v), 32'(wr_ovf), 32'(vecs[v].ovf));
      check($sformatf("v%0d sat cyc_ovf", v), 32'(sa_cyc_ovf), 32'(vecs[v].cyc_ovf));
      check($sformatf("v%0d wrap cyc_ovf", v), 32'(wr_cyc_ovf), 32'(vecs[v].cyc_ovf));
      read_small(2'd3);
      check($sformatf("v%0d sat sel3", v), 32'(sa_rd_data), 32'd0);
    end

    // Sequence A: 10 counting cycles, halt (counted), dump with ready held high
    rst = 1'b1; step(); rst = 1'b0;
    ev = 5'b00011; en = 1'b1;
    repeat (10) step();
    halt = 1'b1; step(); halt = 1'b0;
    ev = 5'b11111;
    dump_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clear = (k == 2);
      halt  = (k == 3);
      #1;
      check($sformatf("A valid %0d", k), 32'(dump_valid), 32'd1);
      check($sformatf("A idx %0d", k), 32'(dump_idx), 32'(k));
      check($sformatf("A data %0d", k), dump_data, exp_a[k]);
      step();
    end
    clear = 1'b0; halt = 1'b0; ev = '0; en = 1'b0; dump_ready = 1'b0;
    check("A done", 32'(done), 32'd1);
    check("A valid after", 32'(dump_valid), 32'd0);
    check("A data after", dump_data, 32'd0);
    check("A ovf", 32'(ovf), 32'd0);
    halt = 1'b1; step(); halt = 1'b0;
    check("A halt in done", 32'(done), 32'd1);
    read_big(3'd0);
    check("A frozen ch0", rd_data, 32'd11);
    read_big(3'd5);
    check("A frozen cyc", rd_data, 32'd11);

    // Sequence B: clear in DONE, recount, dump with stalling ready
    clear = 1'b1; step(); clear = 1'b0;
    check("B done cleared", 32'(done), 32'd0);
    read_big(3'd0);
    check("B ch0 zero", rd_data, 32'd0);
    read_big(3'd5);
    check("B cyc zero", rd_data, 32'd0);
    ev = 5'b00100; en = 1'b1;
    step(); step();
    halt = 1'b1; step(); halt = 1'b0;
    ev = '0; en = 1'b0;
    ptr = 0;
    for (int c = 0; c < 40 && ptr < 6; c++) begin
      dump_ready = pat[c % 4];
      #1;
      check($sformatf("B valid c%0d", c), 32'(dump_valid), 32'd1);
      check($sformatf("B idx c%0d", c), 32'(dump_idx), 32'(ptr));
      check($sformatf("B data c%0d", c), dump_data, exp_b[ptr]);
      check($sformatf("B early done c%0d", c), 32'(done), 32'd0);
      step();
      if (dump_ready) ptr++;
    end
    dump_ready = 1'b0;
    check("B all entries", 32'(ptr), 32'd6);
    check("B done", 32'(done), 32'd1);

    // Sequence C: reset mid-dump at idx 2
    rst = 1'b1; step(); rst = 1'b0;
    ev = 5'b11111; en = 1'b1;
    step(); step();
    halt = 1'b1; step(); halt = 1'b0;
    ev = '0; en = 1'b0;
    dump_ready = 1'b1;
    step(); step();
    check("C idx before rst", 32'(dump_idx), 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    dump_ready = 1'b0;
    check("C valid after rst", 32'(dump_valid), 32'd0);
    check("C done after rst", 32'(done), 32'd0);
    for (int s = 0; s < 6; s++) begin
      read_big(3'(s));
      check($sformatf("C rd %0d zero", s), rd_data, 32'd0);
    end
    ev = 5'b00001; en = 1'b1;
    repeat (4) step();
    ev = '0; en = 1'b0;
    read_big(3'd0);
    check("C ch0 resumed", rd_data, 32'd4);
    read_big(3'd5);
    check("C cyc resumed", rd_data, 32'd4);

    // Sequence D: clear and halt together dump all zeros
    clear = 1'b1; halt = 1'b1; ev = 5'b11111; en = 1'b1;
    step();
    clear = 1'b0; halt = 1'b0; ev = '0; en = 1'b0;
    dump_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("D valid %0d", k), 32'(dump_valid), 32'd1);
      check($sformatf("D idx %0d", k), 32'(dump_idx), 32'(k));
      check($sformatf("D data %0d", k), dump_data, 32'd0);
      step();
    end
    dump_ready = 1'b0;
    check("D done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
- Synthesizable, parametrised event-counter bank for processor performance statistics.
- Counts per-channel events (e.g. retired instruction, I-cache req/hit, D-cache req/hit) plus total cycles.
- On halt, freezes and streams every count out through a valid/ready dump port.
- Sits beside the processor in proc_hier and replaces bench-only counters with in-design hardware readable on silicon.

Parameters:
- NUM_CH, 5, number of event channels (>=1).
- CNT_W, 32, width of each counter and of the cycle counter (>=2).
- SATURATE, 1, overflow mode: 1 = stick at all-ones, 0 = wrap to zero.
- IDX_W, $clog2(NUM_CH+1), derived localparam; width of index fields.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable; when low, channel counters hold (cycle counter still runs in RUN).
- event_in  in  NUM_CH  per-channel event pulse, sampled each cycle.
- halt  in  1  processor halt indication.
- clear  in  1  synchronous clear of all counters and overflow flags.
- rd_sel  in  IDX_W  random-access read select.
- rd_data  out  CNT_W  combinational read: channel rd_sel if < NUM_CH, cycle counter if == NUM_CH, else 0.
- ovf  out  NUM_CH  sticky per-channel overflow flags.
- cyc_ovf  out  1  sticky cycle-counter overflow flag.
- dump_valid  out  1  dump entry valid.
- dump_ready  in  1  consumer accepts dump entry.
- dump_idx  out  IDX_W  index of current dump entry.
- dump_data  out  CNT_W  value of current dump entry.
- done  out  1  dump complete.

Behaviour:
- Reset (rst=1 at clk edge): state=RUN; all counters, ovf, cyc_ovf, dump pointer = 0; dump_valid=0, done=0. Reset has priority over every other input in every state, including mid-dump.
- States: RUN, DUMP, DONE.
- RUN:
  - Cycle counter increments every cycle.
  - Channel i increments when en && event_in[i].
  - Each update takes effect at the clock edge; rd_data reflects it the next cycle.
  - Overflow: an increment at all-ones sets the sticky flag. SATURATE=1 holds the value at all-ones; SATURATE=0 wraps it to 0.
  - Saturated counters do not re-set any other state.
- clear in RUN:
  - Zeros all counters and flags that cycle.
  - Wins over same-cycle events: result is 0, not 1.
  - clear together with halt: counters zeroed, then transition to DUMP. The dump reports zeros, with the cycle counter = 0.
- halt in RUN (clear low):
  - Events and the cycle on the halt cycle are still counted.
  - Next state DUMP with pointer=0.
- DUMP:
  - Counters frozen; event_in, en, halt and clear are ignored.
  - dump_valid=1, dump_idx=pointer, dump_data = entry[pointer]. Entries 0..NUM_CH-1 are channels; entry NUM_CH is the cycle counter.
  - Transfer occurs when dump_valid && dump_ready. The pointer then increments.
  - The transfer of entry NUM_CH moves to DONE.
  - dump_ready low stalls: outputs stable.
  - dump_ready may be held high, giving one entry per cycle: NUM_CH+1 cycles total.
- DONE:
  - dump_valid=0, done=1, counters frozen and readable via rd_sel.
  - clear in DONE: zero counters and flags, done=0, state=RUN on the next cycle.
  - halt is ignored in DONE.
- rd_data and ovf are valid in all states.
- dump_data is only meaningful while dump_valid=1; drive 0 otherwise.

Test Plan:
- NUM_CH=5, CNT_W=32: reset, then 10 cycles with event_in=5'b00011, en=1, then halt -> next cycle dump_valid=1; entries (idx:data) 0:11, 1:11, 2:0, 3:0, 4:0, 5:11 (halt cycle counted); done=1 after the 6th transfer.
- dump_ready toggled 1,0,0,1,... during the dump -> dump_idx/dump_data hold while ready=0; no entry skipped or duplicated; done only after idx 5 is accepted.
- NUM_CH=2, CNT_W=4, SATURATE=1: 17 events on ch0 -> rd_data(sel 0)=15, ovf=2'b01; SATURATE=0 with the same stimulus -> rd_data=1, ovf=2'b01.
- clear and event_in=2'b11 asserted together after 5 counted events -> both channels read 0 the next cycle and ovf=0; en=0 with events -> channels hold while the cycle counter increments.
- rst asserted during DUMP at idx 2 -> next cycle dump_valid=0, done=0, all rd_data=0, state RUN; counting resumes normally.
- In DONE: pulse clear -> done=0, counters 0, and a subsequent halt starts a new dump with correct counts.
